// File: rtl/decision_ctrl_if.sv
// Bus bundle for decision_ctrl: sample input, decided-bit output handshake and status.
// Handshake: bit_out is transferred on a rising clk edge where bit_valid & bit_ready;
// while bit_valid is high and not yet accepted, bit_out is held stable and bit_valid
// stays high. sample_in is taken on every edge where sample_valid is high.
interface decision_ctrl_if #(
    parameter int W = 5
);
    logic [W-1:0] sample_in;
    logic         sample_valid;
    logic         bit_out;
    logic         bit_valid;
    logic         bit_ready;
    logic         cmp_out;
    logic         locked;
    logic         overrun;

    modport master (
        output sample_in, sample_valid, bit_ready,
        input  bit_out, bit_valid, cmp_out, locked, overrun
    );

    modport slave (
        input  sample_in, sample_valid, bit_ready,
        output bit_out, bit_valid, cmp_out, locked, overrun
    );
endinterface

// File: rtl/decision_ctrl.sv
// Symbol-decision controller: moving-average slicer plus per-symbol majority vote.
// Optional symbol realignment on comparator transitions: define DECISION_REALIGN_EN.
module decision_ctrl #(
    parameter int SAMPLES = 2,
    parameter int OSF     = 8
) (
    input logic           clk,
    input logic           rst,
    decision_ctrl_if.slave bus
);
    localparam int N     = SAMPLES * OSF;
    localparam int LOG_N = $clog2(N);
    localparam int W     = LOG_N + 1;
    localparam int S     = W + LOG_N;
    localparam int PW    = (OSF > 2) ? $clog2(OSF) : 1;
    localparam int OW    = $clog2(OSF) + 1;
    localparam logic [PW-1:0] PH_LAST = PW'(OSF - 1);
    localparam logic [OW:0]   OSF_C   = (OW + 1)'(OSF);

    // locked is the state register itself, so the FSM is observable at the port
    typedef enum logic {FILL = 1'b0, TRACK = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    buf_q [N];
    logic [W-1:0]    buf_d [N];
    logic [S-1:0]    sum_q, sum_d;
    logic [LOG_N-1:0] ptr_q, ptr_d;
    logic [LOG_N-1:0] fill_q, fill_d;
    logic [PW-1:0]   phase_q, phase_d;
    logic [OW-1:0]   ones_q, ones_d;
    logic            cmp_q, cmp_d;
    logic            bit_q, bit_d;
    logic            bit_valid_q, bit_valid_d;
    logic            overrun_q, overrun_d;

    logic [S-1:0]    sum_nxt;
    logic [W-1:0]    avg;
    logic            cmp;
    logic [OW-1:0]   ones_inc;
    logic            dec_fire;
    logic            dec_bit;
    logic            take;

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        sum_d       = sum_q;
        ptr_d       = ptr_q;
        fill_d      = fill_q;
        phase_d     = phase_q;
        ones_d      = ones_q;
        cmp_d       = cmp_q;
        bit_d       = bit_q;
        bit_valid_d = bit_valid_q;
        overrun_d   = overrun_q;
        dec_fire    = 1'b0;
        dec_bit     = 1'b0;

        // Average includes the incoming sample and drops the oldest one
        sum_nxt  = sum_q + S'(bus.sample_in) - S'(buf_q[ptr_q]);
        avg      = sum_nxt[S-1:LOG_N];
        cmp      = (bus.sample_in >= avg);
        ones_inc = ones_q + OW'(cmp);
        take     = bit_valid_q & bus.bit_ready;

        if (bus.sample_valid) begin
            sum_d        = sum_nxt;
            buf_d[ptr_q] = bus.sample_in;
            ptr_d        = ptr_q + 1'b1;
            cmp_d        = cmp;
            case (state_q)
                FILL: begin
                    fill_d = fill_q + 1'b1;
                    if (fill_q == LOG_N'(N - 1)) state_d = TRACK;
                end
                TRACK: begin
                    if (phase_q == PH_LAST) begin
                        dec_fire = 1'b1;
                        dec_bit  = ({ones_inc, 1'b0} >= OSF_C);
                        phase_d  = '0;
                        ones_d   = '0;
                    end else begin
`ifdef DECISION_REALIGN_EN
                        if ((cmp != cmp_q) && (phase_q != '0)) begin
                            phase_d = PW'(1);
                            ones_d  = OW'(cmp);
                        end else begin
                            phase_d = phase_q + 1'b1;
                            ones_d  = ones_inc;
                        end
`else
                        phase_d = phase_q + 1'b1;
                        ones_d  = ones_inc;
`endif
                    end
                end
                default: state_d = FILL;
            endcase
        end

        // Single-entry output register; a full, unconsumed register drops new decisions
        if (dec_fire) begin
            if (!bit_valid_q || take) begin
                bit_d       = dec_bit;
                bit_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (take) begin
            bit_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            for (int i = 0; i < N; i++) buf_q[i] <= '0;
            sum_q       <= '0;
            ptr_q       <= '0;
            fill_q      <= '0;
            phase_q     <= '0;
            ones_q      <= '0;
            cmp_q       <= 1'b0;
            bit_q       <= 1'b0;
            bit_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            sum_q       <= sum_d;
            ptr_q       <= ptr_d;
            fill_q      <= fill_d;
            phase_q     <= phase_d;
            ones_q      <= ones_d;
            cmp_q       <= cmp_d;
            bit_q       <= bit_d;
            bit_valid_q <= bit_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.bit_out   = bit_q;
    assign bus.bit_valid = bit_valid_q;
    assign bus.cmp_out   = cmp_q;
    assign bus.locked    = (state_q == TRACK);
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_decision_ctrl.sv
// Bench for decision_ctrl: directed and random samples against a window/symbol reference model.
module tb_decision_ctrl;
  localparam int SAMPLES = 2;
  localparam int OSF     = 8;
  localparam int N       = SAMPLES * OSF;
  localparam int W       = $clog2(N) + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decision_ctrl_if #(.W(W)) bus ();

  decision_ctrl #(.SAMPLES(SAMPLES), .OSF(OSF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int   checks   = 0;
  int   failures = 0;
  logic exp_q[$];
  logic exp_cmp_q[$];

  // reference model: the last N samples, the comparator results of the open symbol
  int   win[$];
  logic sym[$];
  int   count;
  logic last_cmp;
  logic m_valid;
  logic m_over;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    win.delete();
    for (int i = 0; i < N; i++) win.push_back(0);
    sym.delete();
    count    = 0;
    last_cmp = 1'b0;
    m_valid  = 1'b0;
    m_over   = 1'b0;
    exp_q.delete();
    exp_cmp_q.delete();
  endtask

  task automatic model_step(input logic v, input int s, input logic rdy);
    logic take;
    logic dec;
    logic dbit;
    logic c;
    int   sum;
    int   ones;
    take = m_valid && rdy;
    dec  = 1'b0;
    dbit = 1'b0;
    if (v) begin
      win.push_back(s);
      void'(win.pop_front());
      sum = 0;
      foreach (win[i]) sum += win[i];
      c = (s >= sum / N);
      exp_cmp_q.push_back(c);
      if (count < N) begin
        count++;
      end else if (sym.size() == OSF - 1) begin
        sym.push_back(c);
        ones = 0;
        foreach (sym[i]) ones += int'(sym[i]);
        dec  = 1'b1;
        dbit = (2 * ones >= OSF);
        sym.delete();
      end
`ifdef DECISION_REALIGN_EN
      else if (sym.size() != 0 && c != last_cmp) begin
        sym.delete();
        sym.push_back(c);
      end
`endif
      else begin
        sym.push_back(c);
      end
      last_cmp = c;
    end
    if (dec) begin
      if (!m_valid || take) begin
        exp_q.push_back(dbit);
        m_valid = 1'b1;
      end else begin
        m_over = 1'b1;
      end
    end else if (take) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input int s, input logic rdy);
    bus.sample_valid = v;
    bus.sample_in    = W'(s);
    bus.bit_ready    = rdy;
    @(posedge clk);
    #1;
    model_step(v, s, rdy);
  endtask

  task automatic do_reset();
    rst              = 1'b1;
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.bit_ready    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("reset_bit_out", 32'(bus.bit_out), 32'(0));
    check("reset_cmp_out", 32'(bus.cmp_out), 32'(0));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      check("locked", 32'(bus.locked), 32'(count >= N));
      check("overrun", 32'(bus.overrun), 32'(m_over));
      check("bit_valid", 32'(bus.bit_valid), 32'(m_valid));
      if (exp_cmp_q.size() > 0) check("cmp_out", 32'(bus.cmp_out), 32'(exp_cmp_q.pop_front()));
      if (bus.bit_valid && bus.bit_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL bit_out_unexpected actual=%0d required=none t=%0t", bus.bit_out, $time);
        end else begin
          check("bit_out", 32'(bus.bit_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = '0;
    bus.bit_ready    = 1'b0;
    model_reset();
    do_reset();

    // fill: locked only after the N-th sample
    for (int i = 0; i < N - 1; i++) step(1'b1, 10, 1'b1);
    check("not_locked_before_nth", 32'(bus.locked), 32'(0));
    step(1'b1, 10, 1'b1);

    // constant input
    for (int i = 0; i < 4 * OSF; i++) step(1'b1, 10, 1'b1);

    // aligned alternating symbols
    for (int i = 0; i < 8 * OSF; i++) step(1'b1, ((i / OSF) % 2 == 0) ? 20 : 0, 1'b1);

    // tie (4 of 8) and minority (3 of 8) symbols on a flat window
    for (int i = 0; i < N; i++) step(1'b1, 10, 1'b1);
    for (int i = 0; i < OSF; i++) step(1'b1, (i < 4) ? 11 : 0, 1'b1);
    for (int i = 0; i < N; i++) step(1'b1, 10, 1'b1);
    for (int i = 0; i < OSF; i++) step(1'b1, (i < 3) ? 11 : 0, 1'b1);
    repeat (2) step(1'b0, 0, 1'b1);

    // consumer stalls across two decisions, then drains; overrun stays set
    for (int i = 0; i < 2 * OSF; i++) step(1'b1, 10, 1'b0);
    repeat (4) step(1'b0, 0, 1'b1);
    for (int i = 0; i < OSF; i++) step(1'b1, 10, 1'b1);
    repeat (2) step(1'b0, 0, 1'b1);
    do_reset();

    // alternating symbols shifted by 3 samples
    for (int i = 0; i < N; i++) step(1'b1, 10, 1'b1);
    for (int i = 0; i < 8 * OSF; i++) step(1'b1, (((i + 3) / OSF) % 2 == 0) ? 20 : 0, 1'b1);
    repeat (2) step(1'b0, 0, 1'b1);

    // random traffic with a reset in the middle
    for (int i = 0; i < 500; i++) begin
      if (i == 250) do_reset();
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, (1 << W) - 1)),
           $urandom_range(0, 3) != 0);
    end
    repeat (4) step(1'b0, 0, 1'b1);

    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decision_ctrl.md
# decision_ctrl

Symbol-decision controller for the oversampled receive path. It keeps a moving average over the last SAMPLES*OSF input samples and compares each new sample against it (current >= average). It counts oversample phases within a symbol and majority-votes the comparator results into one bit per symbol. Decided bits go out on a valid/ready handshake to the downstream bit consumer.

## Interface
- SAMPLES, 2, symbols spanned by the averaging window
- OSF, 8, oversampling factor (samples per symbol); even, >= 2
- Derived: N = SAMPLES*OSF (must be a power of two), W = $clog2(N)+1 (sample width), S = W+$clog2(N) (sum width)
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- sample_in  input  W  unsigned oversampled input value
- sample_valid  input  1  sample_in valid this cycle (one sample per pulse)
- bit_out  output  1  decided symbol bit
- bit_valid  output  1  bit_out holds an unconsumed decision
- bit_ready  input  1  consumer accepts bit_out when bit_valid & bit_ready
- cmp_out  output  1  registered comparator result of the last accepted sample
- locked  output  1  window filled, decisions active (state TRACK)
- overrun  output  1  sticky, a decision was dropped because the output register was full

## Operation
- Window: N-entry circular buffer of W-bit samples, write pointer 0..N-1, wraps N-1 -> 0.
- Running sum: S bits. On each sample_valid: sum_next = sum + sample_in - buf[ptr], then buf[ptr] = sample_in and ptr advances. Cannot overflow.
- Average: avg = sum_next >> $clog2(N). This is a truncating average and includes the current sample.
- Compare: cmp = (sample_in >= avg), unsigned.
- States:
  - FILL (reset state): accept samples and count them to N. No decisions are made. cmp_out still updates. Go to TRACK on the N-th accepted sample.
  - TRACK: phase counter runs 0..OSF-1 and a ones counter accumulates cmp.
    - At phase OSF-1: bit = 1 when 2*(ones including current) >= OSF. A tie decides 1.
    - Then phase and ones clear.
  - TRACK is left only by rst.
- Output register (single entry):
  - A new decision loads bit_out and sets bit_valid if the register is empty, or if bit_valid & bit_ready in the same cycle.
  - Otherwise the new decision is dropped, overrun is set, and bit_out is unchanged.
- With bit_valid & bit_ready and no new decision: bit_valid clears.
- No sample_valid: all state holds.

## Timing
- Reset values: bit_out=0, bit_valid=0, cmp_out=0, locked=0, overrun=0. Also sum=0, ptr=0, phase=0, ones=0, fill count=0, buffer contents=0.
- cmp_out is registered: valid the cycle after the sample_valid it reflects.
- locked rises the cycle after the N-th sample_valid.
- Decision latency: bit_valid rises the cycle after the sample_valid carrying phase OSF-1.
- The first decision uses samples N+1 .. N+OSF (the first full symbol after fill).
- bit_valid is held until the handshake. bit_out is stable while bit_valid=1.
- Back-to-back sample_valid every cycle is supported, giving full throughput.
- rst asserted mid-symbol or mid-fill: the next cycle equals the reset state. The buffer and sum are cleared, and the partial symbol is discarded.

## Configuration
- DECISION_REALIGN_EN defined:
  - In TRACK, a sample whose cmp differs from the previous sample's cmp, arriving at phase != 0, restarts the symbol. That sample becomes phase 0: phase_next=1, ones=cmp.
  - The partial symbol is discarded with no decision and no overrun.
  - A normal decision at phase OSF-1 takes priority over realign.
  - A transition at phase 0 has no effect.
- DECISION_REALIGN_EN undefined: phase runs freely and transitions are ignored.

## Test plan
- Reset with SAMPLES=2, OSF=8 (N=16, W=5), 15 samples of 10 -> locked=0, bit_valid=0. 16th sample -> locked=1 next cycle.
- Constant 10 after lock, bit_ready=1 -> avg=10, cmp_out=1, one bit_valid pulse per 8 samples, bit_out=1.
- Aligned pattern 8x20 then 8x0 repeating, after lock -> avg=10, bits alternate 1,0,1,0. bit_valid rises 1 cycle after each 8th sample.
- Symbol with exactly 4 of 8 samples >= avg -> bit_out=1 (tie). Symbol with 3 of 8 -> bit_out=0.
- bit_ready=0 across two decisions -> bit_out keeps the first bit, overrun=1 and stays 1 after bit_ready=1. rst -> overrun=0.
- Realign: same pattern as above, shifted by 3 samples.
  - With the macro: one partial symbol dropped, then correct alternating bits.
  - Without the macro: every decision stays mixed, with phase never reset.
